rf_load_sequencer: RTL and testbench

Multi-cycle writer for the 8-entry register file (R1-R4, S1-S4). It fetches four consecutive bytes from a byte-wide memory port with a Req/Ack handshake and assembles them into one 32-bit word. It then commits the word to one destination register by driving I, FunSel, RegSel and ScrSel for exactly one cycle. It sits between the control unit, which issues Start/Dest/BaseAddr, and the register file write port.

---
 rtl/rf_load_sequencer.sv | 102 ++++++++++
 tb/tb_rf_load_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rf_load_sequencer.sv
// Fetches four bytes over a Req/Ack port, assembles a 32-bit word and commits it
// to one register-file destination (R1-R4 / S1-S4) with a single-cycle write.
module rf_load_sequencer #(
  parameter logic [2:0] LOAD_FUNSEL   = 3'b010,
  parameter bit         LITTLE_ENDIAN = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Dest,
  input  logic [15:0] BaseAddr,
  input  logic        Abort,
  input  logic [7:0]  MemData,
  input  logic        MemAck,
  output logic        MemReq,
  output logic [15:0] MemAddr,
  output logic [31:0] I,
  output logic [2:0]  FunSel,
  output logic [3:0]  RegSel,
  output logic [3:0]  ScrSel,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t     state;
  logic [1:0] k;
  logic [2:0] dest;
  logic [4:0] lane_lsb;
  logic [3:0] dest_onehot;

  // Bit offset of the lane that the current byte lands in.
  assign lane_lsb    = LITTLE_ENDIAN ? {k, 3'b000} : 5'(5'd24 - {k, 3'b000});
  assign dest_onehot = 4'b1000 >> dest[1:0];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      k       <= 2'd0;
      dest    <= 3'd0;
      MemReq  <= 1'b0;
      MemAddr <= 16'd0;
      I       <= 32'd0;
      FunSel  <= 3'd0;
      RegSel  <= 4'd0;
      ScrSel  <= 4'd0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            dest    <= Dest;
            MemAddr <= BaseAddr;
            I       <= 32'd0;
            k       <= 2'd0;
            MemReq  <= 1'b1;
            Busy    <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          // Abort wins over a same-cycle acknowledge; that byte is dropped.
          if (Abort) begin
            MemReq <= 1'b0;
            Busy   <= 1'b0;
            state  <= IDLE;
          end else if (MemAck) begin
            I[lane_lsb +: BYTE_W] <= MemData;
            k                     <= k + 2'd1;
            MemAddr               <= MemAddr + 16'd1;
            if (k == 2'd3) begin
              MemReq <= 1'b0;
              FunSel <= LOAD_FUNSEL;
              RegSel <= dest[2] ? 4'd0 : dest_onehot;
              ScrSel <= dest[2] ? dest_onehot : 4'd0;
              state  <= WRITE;
            end
          end
        end
        WRITE: begin
          FunSel <= 3'd0;
          RegSel <= 4'd0;
          ScrSel <= 4'd0;
          Busy   <= 1'b0;
          Done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_load_sequencer.sv
// Randomized bench: little- and big-endian instances share stimulus and are
// checked against a transaction-level model of each load.
module tb_rf_load_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Dest = 3'd0;
  logic [15:0] BaseAddr = 16'd0;
  logic        Abort = 1'b0;
  logic        MemAck = 1'b0;

  logic [7:0]  data_le, data_be;
  logic        req_le, req_be, busy_le, busy_be, done_le, done_be;
  logic [15:0] addr_le, addr_be;
  logic [31:0] i_le, i_be;
  logic [2:0]  fun_le, fun_be;
  logic [3:0]  reg_le, reg_be, scr_le, scr_be;

  logic [7:0]  mem [0:65535];
  int          errors = 0;
  int          checks = 0;

  always #5 Clock = ~Clock;

  assign data_le = mem[addr_le];
  assign data_be = mem[addr_be];

  rf_load_sequencer #(.LOAD_FUNSEL(3'b010), .LITTLE_ENDIAN(1'b1)) dut_le (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Dest(Dest), .BaseAddr(BaseAddr),
    .Abort(Abort), .MemData(data_le), .MemAck(MemAck), .MemReq(req_le),
    .MemAddr(addr_le), .I(i_le), .FunSel(fun_le), .RegSel(reg_le), .ScrSel(scr_le),
    .Busy(busy_le), .Done(done_le));

  rf_load_sequencer #(.LOAD_FUNSEL(3'b010), .LITTLE_ENDIAN(1'b0)) dut_be (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Dest(Dest), .BaseAddr(BaseAddr),
    .Abort(Abort), .MemData(data_be), .MemAck(MemAck), .MemReq(req_be),
    .MemAddr(addr_be), .I(i_be), .FunSel(fun_be), .RegSel(reg_be), .ScrSel(scr_be),
    .Busy(busy_be), .Done(done_be));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Word formed from the first n bytes starting at base.
  function automatic logic [31:0] model_word(input logic [15:0] base, input int n, input bit le);
    logic [31:0] w = 32'd0;
    for (int j = 0; j < n; j++) begin
      if (le) w[8*j +: 8] = mem[16'(base + 16'(j))];
      else    w[24-8*j +: 8] = mem[16'(base + 16'(j))];
    end
    return w;
  endfunction

  // Expected enable: Dest 0..3 -> R1..R4, 4..7 -> S1..S4, with R1/S1 on bit 3.
  function automatic logic [3:0] model_sel(input int d, input bit scratch);
    if ((d >= 4) != scratch) return 4'd0;
    return 4'(1 << (3 - (d % 4)));
  endfunction

  task automatic check_outs(input string tag, input bit req, input bit busy, input bit done,
                            input logic [2:0] fun, input logic [3:0] rs, input logic [3:0] ss);
    check({tag, ".req_le"},  32'(req_le),  32'(req));
    check({tag, ".req_be"},  32'(req_be),  32'(req));
    check({tag, ".busy"},    32'({busy_le, busy_be}), 32'({busy, busy}));
    check({tag, ".done"},    32'({done_le, done_be}), 32'({done, done}));
    check({tag, ".funsel"},  32'({fun_le, fun_be}),   32'({fun, fun}));
    check({tag, ".regsel"},  32'({reg_le, reg_be}),   32'({rs, rs}));
    check({tag, ".scrsel"},  32'({scr_le, scr_be}),   32'({ss, ss}));
  endtask

  task automatic check_data(input string tag, input logic [15:0] addr, input logic [31:0] wle,
                            input logic [31:0] wbe);
    check({tag, ".addr"}, 32'({addr_le, addr_be}), {addr, addr});
    check({tag, ".i_le"}, i_le, wle);
    check({tag, ".i_be"}, i_be, wbe);
  endtask

  // One load: ack_mode 0 = always, 1 = random, 2 = every third cycle.
  task automatic run_load(input logic [2:0] d, input logic [15:0] base, input int ack_mode,
                          input int abort_byte, input bit do_reset, input int busy_start);
    int n = 0;
    int cyc = 0;
    bit ack;
    logic [3:0] er = model_sel(int'(d), 1'b0);
    logic [3:0] es = model_sel(int'(d), 1'b1);
    Start = 1'b1; Dest = d; BaseAddr = base; Abort = 1'b0; MemAck = 1'b0;
    step();
    Start = 1'b0; Dest = 3'($urandom); BaseAddr = 16'($urandom);
    check_outs("fetch0", 1, 1, 0, 3'd0, 4'd0, 4'd0);
    check_data("fetch0", base, 32'd0, 32'd0);
    while (n < 4) begin
      if (cyc > 200) begin
        check("ack_timeout", 32'(cyc), 32'd0);
        return;
      end
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = ($urandom_range(0, 2) != 0);
        default: ack = (cyc % 3 == 2);
      endcase
      if (n == abort_byte) ack = 1'b1;
      MemAck = ack;
      Abort  = (n == abort_byte);
      Start  = (cyc == busy_start);
      if (do_reset && n == 2) begin
        Start = 1'b0; MemAck = 1'b0;
        #2 Reset = 1'b1;
        #1;
        check_outs("async_rst", 0, 0, 0, 3'd0, 4'd0, 4'd0);
        check_data("async_rst", 16'd0, 32'd0, 32'd0);
        step();
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
          step();
          check_outs("post_rst", 0, 0, 0, 3'd0, 4'd0, 4'd0);
        end
        return;
      end
      step();
      cyc++;
      if (Abort) begin
        Abort = 1'b0; MemAck = 1'b0; Start = 1'b0;
        check_outs("abort", 0, 0, 0, 3'd0, 4'd0, 4'd0);
        check_data("abort", 16'(base + 16'(n)), model_word(base, n, 1), model_word(base, n, 0));
        for (int c = 0; c < 4; c++) begin
          step();
          check_outs("post_abort", 0, 0, 0, 3'd0, 4'd0, 4'd0);
        end
        return;
      end
      if (ack) n++;
      if (n < 4) begin
        check_outs("fetch", 1, 1, 0, 3'd0, 4'd0, 4'd0);
        check_data("fetch", 16'(base + 16'(n)), model_word(base, n, 1), model_word(base, n, 0));
      end
    end
    MemAck = 1'b0; Start = 1'b0;
    if (ack_mode == 0) check("fetch_cycles", 32'(cyc), 32'd4);
    check_outs("write", 0, 1, 0, 3'b010, er, es);
    check_data("write", 16'(base + 16'd4), model_word(base, 4, 1), model_word(base, 4, 0));
    step();
    check_outs("done", 0, 0, 1, 3'd0, 4'd0, 4'd0);
    check_data("done", 16'(base + 16'd4), model_word(base, 4, 1), model_word(base, 4, 0));
    step();
    check_outs("idle", 0, 0, 0, 3'd0, 4'd0, 4'd0);
    check_data("idle", 16'(base + 16'd4), model_word(base, 4, 1), model_word(base, 4, 0));
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'h0040] = 8'h11; mem[16'h0041] = 8'h22;
    mem[16'h0042] = 8'h33; mem[16'h0043] = 8'h44;

    step();
    step();
    check_outs("reset", 0, 0, 0, 3'd0, 4'd0, 4'd0);
    check_data("reset", 16'd0, 32'd0, 32'd0);
    Reset = 1'b0;
    step();
    check_outs("idle0", 0, 0, 0, 3'd0, 4'd0, 4'd0);

    run_load(3'd1, 16'h0040, 0, -1, 1'b0, -1);
    check("basic_le_word", i_le, 32'h44332211);
    run_load(3'd6, 16'h0040, 0, -1, 1'b0, -1);
    check("scratch_be_word", i_be, 32'h11223344);
    run_load(3'd3, 16'hFFFE, 2, -1, 1'b0, -1);
    run_load(3'd5, 16'h1234, 0, 2, 1'b0, -1);
    run_load(3'd2, 16'h2000, 1, -1, 1'b1, -1);
    run_load(3'd2, 16'h2000, 0, -1, 1'b0, -1);
    run_load(3'd0, 16'h3000, 0, -1, 1'b0, 1);
    run_load(3'd7, 16'h3100, 2, -1, 1'b0, 4);

    for (int t = 0; t < 24; t++) begin
      run_load(3'($urandom), 16'($urandom), int'($urandom_range(0, 2)),
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1,
               1'b0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
